// File: rtl/sd_sector_dma.sv
// ---------------------------------------------------------------------------
// sd_sector_dma
//
// CPU-programmed multi-sector mover between a local sector buffer and the SD
// card byte streams. The CPU claims a MUTEX and programs LBA and COUNT. It then
// issues READ (card -> buffer), WRITE (buffer -> card) or ABORT through the CMD
// register. Progress and completion are reported in STATUS.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   sd_master_*               32-bit register bus (decode on address[4:2]).
//                             Read data is registered. readdatavalid follows
//                             read by one cycle. waitrequest is tied low.
//   sd_slave_*                buffer port. A read returns data on the next cycle.
//                             A write is a single-cycle strobe.
//   card_start/dir/lba/count  1-cycle command pulse to the card engine. dir,
//                             lba and count are valid with card_start.
//   card_rx_*                 card -> buffer stream. ready is high only in RD_XFER.
//   card_tx_*                 buffer -> card stream. Data is held until ready.
//
// Register map (byte addresses)
//   0x00 MUTEX   0x04 LBA   0x08 COUNT   0x0C CMD   0x10 STATUS
//   STATUS: [0] busy [1] done [2] aborted [3] count_err [15:8] sectors done
// ---------------------------------------------------------------------------
module sd_sector_dma #(
    parameter int DATA_W       = 8,
    parameter int SECTOR_BYTES = 512,
    parameter int BUF_SECTORS  = 4,
    parameter int BUF_AW       = $clog2(SECTOR_BYTES * BUF_SECTORS)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [31:0]         sd_master_address,
    input  logic                sd_master_read,
    input  logic                sd_master_write,
    input  logic [31:0]         sd_master_writedata,
    output logic                sd_master_waitrequest,
    output logic [31:0]         sd_master_readdata,
    output logic                sd_master_readdatavalid,

    output logic [BUF_AW-1:0]   sd_slave_address,
    output logic                sd_slave_read,
    input  logic [DATA_W-1:0]   sd_slave_readdata,
    output logic                sd_slave_write,
    output logic [DATA_W-1:0]   sd_slave_writedata,

    output logic                card_start,
    output logic                card_dir,
    output logic [31:0]         card_lba,
    output logic [7:0]          card_count,
    input  logic                card_rx_valid,
    input  logic [DATA_W-1:0]   card_rx_data,
    output logic                card_rx_ready,
    output logic                card_tx_valid,
    output logic [DATA_W-1:0]   card_tx_data,
    input  logic                card_tx_ready
);

    // Word pointer layout: {sector index, word within sector}. One extra
    // sector bit lets the pointer reach COUNT*SECTOR_BYTES without wrapping.
    localparam int SB_LOG2 = $clog2(SECTOR_BYTES);
    localparam int CW      = $clog2(BUF_SECTORS) + 1;
    localparam int PTR_W   = SB_LOG2 + CW;

    localparam logic [2:0] REG_MUTEX  = 3'd0;
    localparam logic [2:0] REG_LBA    = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMD    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RD_XFER,
        ST_WR_REQ,
        ST_WR_LAT,
        ST_WR_SEND,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                owned_q, owned_d;
    logic [31:0]         lba_q, lba_d;
    logic [7:0]          count_q, count_d;
    logic [CW-1:0]       xfer_cnt_q, xfer_cnt_d;
    logic                dir_q, dir_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic                count_err_q, count_err_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                rdvalid_q, rdvalid_d;

    logic [2:0]          reg_idx;
    logic                cmd_wr_sel;
    logic                cmd_read, cmd_write, cmd_abort;
    logic                busy;
    logic [PTR_W-1:0]    xfer_total;
    logic                ptr_last;
    logic [31:0]         status_word;
    logic                unused_addr_bits;

    assign reg_idx    = sd_master_address[4:2];
    assign cmd_wr_sel = sd_master_write && (reg_idx == REG_CMD);
    assign cmd_read   = cmd_wr_sel && (sd_master_writedata == 32'd2);
    assign cmd_write  = cmd_wr_sel && (sd_master_writedata == 32'd3);
    assign cmd_abort  = cmd_wr_sel && (sd_master_writedata == 32'd1);

    assign busy       = (state_q != ST_IDLE);
    assign xfer_total = {xfer_cnt_q, {SB_LOG2{1'b0}}};
    assign ptr_last   = (ptr_q == (xfer_total - PTR_W'(1)));

    // Only address bits [4:2] select a register. The remaining bits are
    // deliberately ignored, so the map aliases across the window.
    assign unused_addr_bits = &{1'b0, sd_master_address[31:5], sd_master_address[1:0]};

    always_comb begin
        status_word        = '0;
        status_word[15:8]  = 8'(ptr_q[PTR_W-1:SB_LOG2]);
        status_word[3:0]   = {count_err_q, aborted_q, done_q, busy};
    end

    assign sd_master_waitrequest   = 1'b0;
    assign sd_master_readdata      = readdata_q;
    assign sd_master_readdatavalid = rdvalid_q;

    always_comb begin
        // hold state by default
        state_d     = state_q;
        owned_d     = owned_q;
        lba_d       = lba_q;
        count_d     = count_q;
        xfer_cnt_d  = xfer_cnt_q;
        dir_d       = dir_q;
        ptr_d       = ptr_q;
        done_d      = done_q;
        aborted_d   = aborted_q;
        count_err_d = count_err_q;
        tx_data_d   = tx_data_q;
        readdata_d  = '0;
        rdvalid_d   = sd_master_read;

        // outputs idle low
        sd_slave_address   = '0;
        sd_slave_read      = 1'b0;
        sd_slave_write     = 1'b0;
        sd_slave_writedata = '0;
        card_start         = 1'b0;
        card_dir           = 1'b0;
        card_lba           = '0;
        card_count         = '0;
        card_rx_ready      = 1'b0;
        card_tx_valid      = 1'b0;
        card_tx_data       = '0;

        // Register reads sample the pre-update values. Any side effects
        // (mutex claim, sticky clear) come first, so writes and FSM events
        // later in this block override them.
        if (sd_master_read) begin
            case (reg_idx)
                REG_MUTEX: begin
                    readdata_d = {31'd0, ~owned_q};
                    owned_d    = 1'b1;
                end
                REG_LBA:   readdata_d = lba_q;
                REG_COUNT: readdata_d = {24'd0, count_q};
                REG_STATUS: begin
                    readdata_d  = status_word;
                    done_d      = 1'b0;
                    aborted_d   = 1'b0;
                    count_err_d = 1'b0;
                end
                default:   readdata_d = '0;
            endcase
        end

        if (sd_master_write) begin
            case (reg_idx)
                REG_MUTEX: if (sd_master_writedata == 32'd0) owned_d = 1'b0;
                REG_LBA:   lba_d   = sd_master_writedata;
                REG_COUNT: count_d = sd_master_writedata[7:0];
                default:   ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_read || cmd_write) begin
                    if ((count_q == 8'd0) || (count_q > 8'(BUF_SECTORS))) begin
                        count_err_d = 1'b1;
                    end else begin
                        done_d      = 1'b0;
                        aborted_d   = 1'b0;
                        count_err_d = 1'b0;
                        dir_d       = cmd_write;
                        xfer_cnt_d  = count_q[CW-1:0];
                        ptr_d       = '0;
                        state_d     = ST_START;
                    end
                end
            end
            ST_START: begin
                card_start = 1'b1;
                card_dir   = dir_q;
                card_lba   = lba_q;
                card_count = 8'(xfer_cnt_q);
                state_d    = dir_q ? ST_WR_REQ : ST_RD_XFER;
            end
            ST_RD_XFER: begin
                card_rx_ready = 1'b1;
                if (card_rx_valid) begin
                    sd_slave_write     = 1'b1;
                    sd_slave_address   = ptr_q[BUF_AW-1:0];
                    sd_slave_writedata = card_rx_data;
                    ptr_d              = ptr_q + 1'b1;
                    if (ptr_last) state_d = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                sd_slave_read    = 1'b1;
                sd_slave_address = ptr_q[BUF_AW-1:0];
                state_d          = ST_WR_LAT;
            end
            ST_WR_LAT: begin
                // buffer data for the read issued last cycle is valid now
                tx_data_d = sd_slave_readdata;
                state_d   = ST_WR_SEND;
            end
            ST_WR_SEND: begin
                card_tx_valid = 1'b1;
                card_tx_data  = tx_data_q;
                if (card_tx_ready) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ptr_last ? ST_DONE : ST_WR_REQ;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any in-flight progress. The buffer keeps whatever
        // was already written.
        if (cmd_abort && busy) begin
            aborted_d = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owned_q     <= 1'b0;
            lba_q       <= '0;
            count_q     <= '0;
            xfer_cnt_q  <= '0;
            dir_q       <= 1'b0;
            ptr_q       <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            count_err_q <= 1'b0;
            tx_data_q   <= '0;
            readdata_q  <= '0;
            rdvalid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owned_q     <= owned_d;
            lba_q       <= lba_d;
            count_q     <= count_d;
            xfer_cnt_q  <= xfer_cnt_d;
            dir_q       <= dir_d;
            ptr_q       <= ptr_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            count_err_q <= count_err_d;
            tx_data_q   <= tx_data_d;
            readdata_q  <= readdata_d;
            rdvalid_q   <= rdvalid_d;
        end
    end

endmodule

// File: tb/tb_sd_sector_dma.sv
// ---------------------------------------------------------------------------
// tb_sd_sector_dma
//
// Directed bench for sd_sector_dma. It models the sector buffer (registered
// read) and the card streams, and checks against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sd_sector_dma;

    localparam int DATA_W = 8;
    localparam int SB     = 512;
    localparam int BS     = 4;
    localparam int AW     = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       sd_master_address;
    logic              sd_master_read;
    logic              sd_master_write;
    logic [31:0]       sd_master_writedata;
    logic              sd_master_waitrequest;
    logic [31:0]       sd_master_readdata;
    logic              sd_master_readdatavalid;
    logic [AW-1:0]     sd_slave_address;
    logic              sd_slave_read;
    logic [DATA_W-1:0] sd_slave_readdata;
    logic              sd_slave_write;
    logic [DATA_W-1:0] sd_slave_writedata;
    logic              card_start;
    logic              card_dir;
    logic [31:0]       card_lba;
    logic [7:0]        card_count;
    logic              card_rx_valid;
    logic [DATA_W-1:0] card_rx_data;
    logic              card_rx_ready;
    logic              card_tx_valid;
    logic [DATA_W-1:0] card_tx_data;
    logic              card_tx_ready;

    always #5 clk = ~clk;

    sd_sector_dma #(
        .DATA_W(DATA_W), .SECTOR_BYTES(SB), .BUF_SECTORS(BS), .BUF_AW(AW)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .sd_master_address      (sd_master_address),
        .sd_master_read         (sd_master_read),
        .sd_master_write        (sd_master_write),
        .sd_master_writedata    (sd_master_writedata),
        .sd_master_waitrequest  (sd_master_waitrequest),
        .sd_master_readdata     (sd_master_readdata),
        .sd_master_readdatavalid(sd_master_readdatavalid),
        .sd_slave_address       (sd_slave_address),
        .sd_slave_read          (sd_slave_read),
        .sd_slave_readdata      (sd_slave_readdata),
        .sd_slave_write         (sd_slave_write),
        .sd_slave_writedata     (sd_slave_writedata),
        .card_start             (card_start),
        .card_dir               (card_dir),
        .card_lba               (card_lba),
        .card_count             (card_count),
        .card_rx_valid          (card_rx_valid),
        .card_rx_data           (card_rx_data),
        .card_rx_ready          (card_rx_ready),
        .card_tx_valid          (card_tx_valid),
        .card_tx_data           (card_tx_data),
        .card_tx_ready          (card_tx_ready)
    );

    // Sector buffer model: one-cycle registered read, preloaded with addr[7:0].
    logic [7:0] mem [0:2047];
    logic [7:0] rd_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < 2048; m++) mem[m] <= m[7:0];
            rd_q <= '0;
        end else begin
            if (sd_slave_read)  rd_q <= mem[sd_slave_address];
            if (sd_slave_write) mem[sd_slave_address] <= sd_slave_writedata;
        end
    end
    assign sd_slave_readdata = rd_q;

    // Event monitor: card_start pulses and buffer writes.
    int          start_cnt = 0;
    int          wr_cnt    = 0;
    logic [31:0] st_lba    = '0;
    logic        st_dir    = 1'b0;
    logic [7:0]  st_count  = '0;
    always @(posedge clk) begin
        if (card_start) begin
            start_cnt <= start_cnt + 1;
            st_lba    <= card_lba;
            st_dir    <= card_dir;
            st_count  <= card_count;
        end
        if (sd_slave_write) wr_cnt <= wr_cnt + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sd_master_address   = a;
        sd_master_writedata = d;
        sd_master_write     = 1'b1;
        @(negedge clk);
        sd_master_write     = 1'b0;
        $display("reg write addr=0x%02h data=0x%08h", a, d);
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sd_master_address = a;
        sd_master_read    = 1'b1;
        @(negedge clk);
        sd_master_read    = 1'b0;
        check("rdvalid", {31'd0, sd_master_readdatavalid}, 32'd1);
        d = sd_master_readdata;
        $display("reg read  addr=0x%02h data=0x%08h", a, d);
    endtask

    initial begin
        logic [31:0]  d;
        int           i;
        int           k;
        int           bad;
        int           data_bad;
        int           stall_bad;
        int           s0;
        int           w0;
        logic         prev_stall;
        logic [7:0]   prev_d;
        logic         issued;
        logic [106:0] outs;

        rst                 = 1'b1;
        sd_master_address   = '0;
        sd_master_read      = 1'b0;
        sd_master_write     = 1'b0;
        sd_master_writedata = '0;
        card_rx_valid       = 1'b0;
        card_rx_data        = '0;
        card_tx_ready       = 1'b0;

        // ---- 1: reset and mutex ----
        repeat (3) @(negedge clk);
        check("t1_rdvalid_reset", {31'd0, sd_master_readdatavalid}, 32'd0);
        check("t1_waitrequest",   {31'd0, sd_master_waitrequest},   32'd0);
        rst = 1'b0;
        reg_read(32'h10, d); check("t1_status_reset", d, 32'h0);
        reg_read(32'h00, d); check("t1_mutex_first",  d, 32'd1);
        reg_read(32'h00, d); check("t1_mutex_second", d, 32'd0);
        reg_write(32'h00, 32'd0);
        reg_read(32'h00, d); check("t1_mutex_release", d, 32'd1);

        // ---- 2: single-sector READ ----
        reg_write(32'h04, 32'd5);
        reg_write(32'h08, 32'd1);
        s0 = start_cnt; w0 = wr_cnt;
        reg_write(32'h0C, 32'd2);
        i = 0; bad = 0;
        for (int cyc = 0; cyc < 3000 && i < 512; cyc++) begin
            @(negedge clk);
            card_rx_valid = 1'b1;
            card_rx_data  = i[7:0];
            #1;
            if (card_rx_ready) begin
                if (!(sd_slave_write && sd_slave_address == i[10:0] &&
                      sd_slave_writedata == i[7:0])) bad++;
                i++;
            end
        end
        @(negedge clk);
        card_rx_valid = 1'b0;
        check("t2_rx_count",  i, 512);
        check("t2_wr_bad",    bad, 0);
        check("t2_wr_cnt",    wr_cnt - w0, 512);
        check("t2_start_cnt", start_cnt - s0, 1);
        check("t2_lba",       st_lba, 32'd5);
        check("t2_dir",       {31'd0, st_dir}, 32'd0);
        check("t2_count",     {24'd0, st_count}, 32'd1);
        repeat (4) @(negedge clk);
        reg_read(32'h10, d); check("t2_status", d, 32'h0102);

        // ---- 3: two-sector WRITE with random tx stalls ----
        reg_write(32'h08, 32'd2);
        s0 = start_cnt;
        reg_write(32'h0C, 32'd3);
        k = 0; data_bad = 0; stall_bad = 0; prev_stall = 1'b0; prev_d = '0;
        for (int cyc = 0; cyc < 30000 && k < 1024; cyc++) begin
            @(negedge clk);
            card_tx_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall && !(card_tx_valid && card_tx_data == prev_d)) stall_bad++;
            prev_stall = 1'b0;
            if (card_tx_valid) begin
                if (card_tx_data != k[7:0]) data_bad++;
                if (card_tx_ready) k++;
                else begin
                    prev_stall = 1'b1;
                    prev_d     = card_tx_data;
                end
            end
        end
        @(negedge clk);
        card_tx_ready = 1'b0;
        check("t3_tx_count",  k, 1024);
        check("t3_tx_data",   data_bad, 0);
        check("t3_tx_stable", stall_bad, 0);
        check("t3_start_cnt", start_cnt - s0, 1);
        check("t3_dir",       {31'd0, st_dir}, 32'd1);
        check("t3_count",     {24'd0, st_count}, 32'd2);
        repeat (4) @(negedge clk);
        reg_read(32'h10, d); check("t3_status", d, 32'h0202);

        // ---- 4: illegal counts ----
        reg_write(32'h08, 32'd0);
        s0 = start_cnt;
        reg_write(32'h0C, 32'd2);
        repeat (4) @(negedge clk);
        check("t4a_no_start", start_cnt - s0, 0);
        reg_read(32'h10, d); check("t4a_status_lo", {28'd0, d[3:0]}, 32'h8);
        reg_write(32'h08, 32'd5);
        reg_write(32'h0C, 32'd2);
        repeat (4) @(negedge clk);
        check("t4b_no_start", start_cnt - s0, 0);
        reg_read(32'h10, d); check("t4b_status_lo", {28'd0, d[3:0]}, 32'h8);

        // ---- 5: READ aborted after 100 bytes, stray WRITE ignored ----
        reg_write(32'h08, 32'd1);
        s0 = start_cnt; w0 = wr_cnt;
        reg_write(32'h0C, 32'd2);
        i = 0; issued = 1'b0;
        for (int cyc = 0; cyc < 2000 && i < 100; cyc++) begin
            @(negedge clk);
            card_rx_valid = 1'b1;
            card_rx_data  = i[7:0];
            if (i == 50 && !issued) begin
                sd_master_address   = 32'h0C;
                sd_master_writedata = 32'd3;
                sd_master_write     = 1'b1;
                issued              = 1'b1;
            end else begin
                sd_master_write = 1'b0;
            end
            #1;
            if (card_rx_ready) i++;
        end
        @(negedge clk);
        card_rx_valid       = 1'b0;
        sd_master_address   = 32'h0C;
        sd_master_writedata = 32'd1;
        sd_master_write     = 1'b1;
        @(negedge clk);
        sd_master_write = 1'b0;
        card_rx_valid   = 1'b1;
        #1;
        check("t5_rx_ready_off",  {31'd0, card_rx_ready},  32'd0);
        check("t5_buf_write_off", {31'd0, sd_slave_write}, 32'd0);
        @(negedge clk);
        card_rx_valid = 1'b0;
        check("t5_rx_count", i, 100);
        check("t5_wr_cnt",   wr_cnt - w0, 100);
        repeat (3) @(negedge clk);
        check("t5_start_cnt", start_cnt - s0, 1);
        check("t5_dir",       {31'd0, st_dir}, 32'd0);
        reg_read(32'h10, d); check("t5_status", d, 32'h0004);

        // ---- 6: reset during WRITE at word 37 ----
        reg_write(32'h08, 32'd1);
        reg_write(32'h0C, 32'd3);
        k = 0;
        card_tx_ready = 1'b1;
        for (int cyc = 0; cyc < 500 && k < 37; cyc++) begin
            @(negedge clk);
            #1;
            if (card_tx_valid) k++;
        end
        check("t6_tx_count", k, 37);
        @(negedge clk);
        rst           = 1'b1;
        card_tx_ready = 1'b0;
        @(negedge clk);
        #1;
        outs = {sd_master_waitrequest, sd_master_readdatavalid, sd_master_readdata,
                sd_slave_address, sd_slave_read, sd_slave_write, sd_slave_writedata,
                card_start, card_dir, card_lba, card_count, card_rx_ready,
                card_tx_valid, card_tx_data};
        check("t6_outputs_zero", {31'd0, |outs}, 32'd0);
        rst = 1'b0;
        s0 = start_cnt;
        repeat (3) @(negedge clk);
        check("t6_no_start", start_cnt - s0, 0);
        reg_read(32'h10, d); check("t6_status", d, 32'h0);
        reg_read(32'h00, d); check("t6_mutex_free", d, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
